noc_local_injector: RTL and testbench

Packetizer that drives a router's local input port. It accepts a packet command (destination plus payload length) and a stream of 32-bit payload words from the attached processing element. It formats them into head/body/tail flits and injects them over the NoC flit sender handshake, one virtual channel locked per packet. It sits between the tile's compute logic and the router's local receiver port.

---
 rtl/noc_local_injector.sv | 133 +++++++++++++
 tb/tb_noc_local_injector.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/noc_local_injector.sv
// Local-port packetizer: turns a (dst, len) command plus a payload word stream into
// head/body/tail flits, injected on one round-robin-selected VC locked for the whole packet.
module noc_local_injector #(
  parameter int CHANNELS   = 2,
  parameter int ID_X_W     = 4,
  parameter int ID_Y_W     = 4,
  parameter int LEN_W      = 8,
  parameter int FLIT_WIDTH = 34
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  input  logic [ID_X_W-1:0]     id_x,
  input  logic [ID_Y_W-1:0]     id_y,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_X_W-1:0]     cmd_dst_x,
  input  logic [ID_Y_W-1:0]     cmd_dst_y,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [31:0]           data,
  output logic [CHANNELS-1:0]   tx_valid,
  output logic [FLIT_WIDTH-1:0] tx_flit,
  input  logic [CHANNELS-1:0]   tx_ready,
  input  logic [CHANNELS-1:0]   tx_vc_ready,
  output logic                  busy,
  output logic [15:0]           pkt_sent
);

  localparam int VC_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PL_W  = FLIT_WIDTH - 2;
  localparam int HDR_W = 2*ID_X_W + 2*ID_Y_W + LEN_W;
  localparam int PAD_W = PL_W - HDR_W;

  typedef enum logic {IDLE, BODY} state_t;

  state_t                state, state_nxt;
  logic                  out_valid;
  logic [VC_W-1:0]       out_vc;
  logic [VC_W-1:0]       rr_ptr, rr_nxt;
  logic [LEN_W-1:0]      rem, rem_nxt;
  logic                  fire, load_ok, load;
  logic [VC_W-1:0]       load_vc;
  logic [FLIT_WIDTH-1:0] load_flit;
  logic [PL_W-1:0]       head_pl;
  logic                  found;
  int unsigned           sel_i;
  logic [VC_W-1:0]       sel_vc;

  // Round-robin scan: first VC free to start a packet at or after rr_ptr.
  always_comb begin
    int unsigned base;
    int unsigned idx;
    found = 1'b0;
    sel_i = 0;
    base  = 32'(rr_ptr);
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = (base + i) % CHANNELS;
      if (!found && tx_vc_ready[VC_W'(idx)]) begin
        found = 1'b1;
        sel_i = idx;
      end
    end
    sel_vc = VC_W'(sel_i);
  end

  assign fire     = out_valid & tx_ready[out_vc];
  assign load_ok  = !out_valid | fire;
  assign tx_valid = (noc_rst_n && out_valid) ? (CHANNELS'(1) << out_vc) : '0;
  assign busy     = noc_rst_n & ((state == BODY) | out_valid);
  assign head_pl  = PL_W'({cmd_dst_x, cmd_dst_y, id_x, id_y, cmd_len}) << PAD_W;

  always_comb begin
    state_nxt  = state;
    rem_nxt    = rem;
    rr_nxt     = rr_ptr;
    load       = 1'b0;
    load_vc    = out_vc;
    load_flit  = tx_flit;
    cmd_ready  = 1'b0;
    data_ready = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = noc_rst_n & load_ok & found;
        if (cmd_valid && cmd_ready) begin
          load      = 1'b1;
          load_vc   = sel_vc;
          rr_nxt    = VC_W'((sel_i + 1) % CHANNELS);
          load_flit = {(cmd_len == '0) ? 2'b11 : 2'b01, head_pl};
          rem_nxt   = cmd_len;
          if (cmd_len != '0) state_nxt = BODY;
        end
      end
      BODY: begin
        data_ready = noc_rst_n & load_ok;
        if (data_valid && data_ready) begin
          // Type and exit decision both use rem before the decrement.
          load      = 1'b1;
          load_flit = {(rem == LEN_W'(1)) ? 2'b10 : 2'b00, PL_W'(data)};
          rem_nxt   = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_vc    <= '0;
      tx_flit   <= '0;
      rr_ptr    <= '0;
      rem       <= '0;
      pkt_sent  <= '0;
    end else begin
      state  <= state_nxt;
      rem    <= rem_nxt;
      rr_ptr <= rr_nxt;
      // Outgoing flit is counted on fire even when a new one replaces it this cycle.
      if (fire && tx_flit[FLIT_WIDTH-1]) pkt_sent <= pkt_sent + 16'd1;
      if (load) begin
        out_valid <= 1'b1;
        out_vc    <= load_vc;
        tx_flit   <= load_flit;
      end else if (fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_noc_local_injector.sv
// Directed bench for noc_local_injector: 2 VCs, own id (1,2), 34-bit flits.
module tb_noc_local_injector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  id_x, id_y;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_dst_x, cmd_dst_y;
  logic [7:0]  cmd_len;
  logic        data_valid, data_ready;
  logic [31:0] data;
  logic [1:0]  tx_valid, tx_ready, tx_vc_ready;
  logic [33:0] tx_flit;
  logic        busy;
  logic [15:0] pkt_sent;

  int n_checks = 0;
  int n_errors = 0;

  noc_local_injector #(
    .CHANNELS(2), .ID_X_W(4), .ID_Y_W(4), .LEN_W(8), .FLIT_WIDTH(34)
  ) dut (
    .noc_clk(clk), .noc_rst_n(rst_n), .id_x(id_x), .id_y(id_y),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dst_x(cmd_dst_x),
    .cmd_dst_y(cmd_dst_y), .cmd_len(cmd_len), .data_valid(data_valid),
    .data_ready(data_ready), .data(data), .tx_valid(tx_valid), .tx_flit(tx_flit),
    .tx_ready(tx_ready), .tx_vc_ready(tx_vc_ready), .busy(busy), .pkt_sent(pkt_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [33:0] head_f(input logic [1:0] t, input logic [3:0] dx,
                                         input logic [3:0] dy, input logic [7:0] len);
    return {t, dx, dy, 4'd1, 4'd2, len, 8'h00};
  endfunction

  function automatic logic [33:0] word_f(input logic [1:0] t, input logic [31:0] d);
    return {t, d};
  endfunction

  task automatic set_cmd(input logic v, input logic [3:0] dx, input logic [3:0] dy,
                         input logic [7:0] len);
    cmd_valid = v; cmd_dst_x = dx; cmd_dst_y = dy; cmd_len = len;
  endtask

  initial begin
    id_x = 4'd1; id_y = 4'd2;
    rst_n = 1'b0;
    set_cmd(1'b1, 4'd0, 4'd0, 8'd0);
    data_valid = 1'b0; data = '0;
    tx_ready = 2'b11; tx_vc_ready = 2'b11;
    tick(); tick();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_data_ready", 64'(data_ready), 64'd0);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tx_flit", 64'(tx_flit), 64'd0);
    check("rst_pkt_sent", 64'(pkt_sent), 64'd0);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Packet len=3, dst (3,0), words A,B,C; word A waits while still in IDLE.
    set_cmd(1'b1, 4'd3, 4'd0, 8'd3);
    data_valid = 1'b1; data = 32'hAAAA_0001;
    #1;
    check("p1_cmd_ready", 64'(cmd_ready), 64'd1);
    check("p1_idle_data_ready", 64'(data_ready), 64'd0);
    tick();
    cmd_valid = 1'b0;
    check("p1_head_valid", 64'(tx_valid), 64'b01);
    check("p1_head_flit", 64'(tx_flit), 64'(head_f(2'b01, 4'd3, 4'd0, 8'd3)));
    check("p1_busy", 64'(busy), 64'd1);
    check("p1_body_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    check("p1_A", 64'(tx_flit), 64'(word_f(2'b00, 32'hAAAA_0001)));
    data = 32'hBBBB_0002;
    tick();
    check("p1_B", 64'(tx_flit), 64'(word_f(2'b00, 32'hBBBB_0002)));
    data = 32'hCCCC_0003;
    tick();
    check("p1_C_tail", 64'(tx_flit), 64'(word_f(2'b10, 32'hCCCC_0003)));
    check("p1_C_valid", 64'(tx_valid), 64'b01);
    check("p1_pkt_before", 64'(pkt_sent), 64'd0);
    data_valid = 1'b0;
    tick();
    check("p1_pkt_sent", 64'(pkt_sent), 64'd1);
    check("p1_done_valid", 64'(tx_valid), 64'd0);
    check("p1_done_busy", 64'(busy), 64'd0);

    // len=0 single flit; rr_ptr now 1 -> VC1. Payload port stays closed.
    set_cmd(1'b1, 4'd2, 4'd1, 8'd0);
    data_valid = 1'b1; data = 32'hDDDD_0004;
    tick();
    cmd_valid = 1'b0;
    check("p2_valid", 64'(tx_valid), 64'b10);
    check("p2_flit", 64'(tx_flit), 64'(head_f(2'b11, 4'd2, 4'd1, 8'd0)));
    check("p2_data_ready", 64'(data_ready), 64'd0);
    tick();
    check("p2_pkt_sent", 64'(pkt_sent), 64'd2);
    check("p2_data_ready_after", 64'(data_ready), 64'd0);
    check("p2_valid_after", 64'(tx_valid), 64'd0);

    // Back-to-back len=1 packets: VC0 then VC1, next head loads as tail fires.
    set_cmd(1'b1, 4'd1, 4'd1, 8'd1);
    data = 32'hEEEE_0005;
    tick();
    cmd_valid = 1'b0;
    check("p3a_head_valid", 64'(tx_valid), 64'b01);
    check("p3a_head", 64'(tx_flit), 64'(head_f(2'b01, 4'd1, 4'd1, 8'd1)));
    tick();
    set_cmd(1'b1, 4'd0, 4'd3, 8'd1);
    data = 32'hFFFF_0006;
    #1;
    check("p3a_tail", 64'(tx_flit), 64'(word_f(2'b10, 32'hEEEE_0005)));
    check("p3b_cmd_ready_on_fire", 64'(cmd_ready), 64'd1);
    check("p3_idle_data_ready", 64'(data_ready), 64'd0);
    tick();
    cmd_valid = 1'b0;
    check("p3b_head_valid", 64'(tx_valid), 64'b10);
    check("p3b_head", 64'(tx_flit), 64'(head_f(2'b01, 4'd0, 4'd3, 8'd1)));
    check("p3a_pkt_sent", 64'(pkt_sent), 64'd3);
    tick();
    check("p3b_tail", 64'(tx_flit), 64'(word_f(2'b10, 32'hFFFF_0006)));
    check("p3b_tail_valid", 64'(tx_valid), 64'b10);
    data_valid = 1'b0;
    tick();
    check("p3b_pkt_sent", 64'(pkt_sent), 64'd4);

    // Stall: VC0 not ready for 5 cycles; VC1 readiness must be ignored.
    set_cmd(1'b1, 4'd3, 4'd3, 8'd2);
    tick();
    cmd_valid = 1'b0;
    check("p4_rr_wrap_vc0", 64'(tx_valid), 64'b01);
    tx_ready = 2'b10;
    data_valid = 1'b1; data = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("p4_stall_data_ready", 64'(data_ready), 64'd0);
      check("p4_stall_flit", 64'(tx_flit), 64'(head_f(2'b01, 4'd3, 4'd3, 8'd2)));
      check("p4_stall_valid", 64'(tx_valid), 64'b01);
      tick();
    end
    tx_ready = 2'b11;
    #1;
    check("p4_resume_data_ready", 64'(data_ready), 64'd1);
    tick();
    check("p4_G", 64'(tx_flit), 64'(word_f(2'b00, 32'h1234_5678)));
    data = 32'h9ABC_DEF0;
    tick();
    check("p4_H_tail", 64'(tx_flit), 64'(word_f(2'b10, 32'h9ABC_DEF0)));
    data_valid = 1'b0;
    tick();
    check("p4_pkt_sent", 64'(pkt_sent), 64'd5);

    // No free VC: command held off until VC1 frees up.
    tx_vc_ready = 2'b00;
    set_cmd(1'b1, 4'd1, 4'd0, 8'd0);
    #1;
    check("p5_cmd_ready_blocked", 64'(cmd_ready), 64'd0);
    tick();
    check("p5_no_valid", 64'(tx_valid), 64'd0);
    tx_vc_ready = 2'b10;
    #1;
    check("p5_cmd_ready_vc1", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    check("p5_valid_vc1", 64'(tx_valid), 64'b10);
    check("p5_flit", 64'(tx_flit), 64'(head_f(2'b11, 4'd1, 4'd0, 8'd0)));
    tick();
    check("p5_pkt_sent", 64'(pkt_sent), 64'd6);

    // Reset after the head of a len=4 packet abandons it.
    tx_vc_ready = 2'b11;
    set_cmd(1'b1, 4'd2, 4'd2, 8'd4);
    tick();
    cmd_valid = 1'b0;
    check("p6_head_valid", 64'(tx_valid), 64'b01);
    tx_ready = 2'b00;
    rst_n = 1'b0;
    #1;
    check("p6_rst_valid_comb", 64'(tx_valid), 64'd0);
    check("p6_rst_busy_comb", 64'(busy), 64'd0);
    tick();
    check("p6_rst_valid", 64'(tx_valid), 64'd0);
    check("p6_rst_busy", 64'(busy), 64'd0);
    check("p6_rst_flit", 64'(tx_flit), 64'd0);
    check("p6_rst_pkt_sent", 64'(pkt_sent), 64'd0);
    rst_n = 1'b1; tx_ready = 2'b11;
    tick();
    data_valid = 1'b1; data = 32'h5555_AAAA;
    set_cmd(1'b1, 4'd1, 4'd1, 8'd0);
    #1;
    check("p6_idle_data_ready", 64'(data_ready), 64'd0);
    check("p6_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0; data_valid = 1'b0;
    check("p6_new_valid", 64'(tx_valid), 64'b01);
    check("p6_new_flit", 64'(tx_flit), 64'(head_f(2'b11, 4'd1, 4'd1, 8'd0)));
    tick();
    check("p6_pkt_sent", 64'(pkt_sent), 64'd1);
    check("p6_busy_end", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
